// File: rtl/pending_encoder.sv
// pending_encoder
// Sticky request capture in front of an 8-to-3 priority encoder with a
// valid/ready output. Request pulses on data_in are OR-ed into a pending
// register. The lowest-indexed pending line is presented as a binary code,
// and that line is cleared when the consumer accepts the code.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   data_in  [N-1:0]     request pulses, bit k raises request k
//   data_out [OUT_W-1:0] index of the request being presented
//   valid    data_out holds a pending request
//   ready    consumer accepts data_out when valid && ready
//   pending  [N-1:0]     sticky pending register
//   overflow one-cycle pulse: a request hit an already-pending bit
module pending_encoder #(
  parameter int unsigned N     = 8,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     clr;
  logic [N-1:0]     remain;
  logic [OUT_W-1:0] sel;
  logic             sel_found;
  logic             accept;

  assign accept = (state_q == PRESENT) && ready;

  // The accepted line is dropped before selection so the next code can be
  // presented on the very next cycle without a bubble.
  always_comb begin
    clr = '0;
    if (accept) begin
      clr[dout_q] = 1'b1;
    end
  end

  assign remain = pend_q & ~clr;

  // Lowest set bit wins; selection never looks at data_in directly.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (remain[i] && !sel_found) begin
        sel       = OUT_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // A set on the same cycle as the clear re-arms the line (set wins).
  assign pend_d = remain | data_in;
  assign ovf_d  = |(data_in & remain);

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          dout_d  = sel;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) begin
          if (sel_found) begin
            dout_d = sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = dout_q;
  assign valid    = (state_q == PRESENT);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model.
module tb_pending_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [2:0] data_out;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  pending_encoder #(.N(8), .OUT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending as a bit set, output as (valid, code).
  bit [7:0] m_pend  = '0;
  bit       m_valid = 1'b0;
  int       m_code  = 0;
  bit       m_ovf   = 1'b0;
  bit       model_on = 1'b0;

  always @(posedge clk) begin
    automatic bit [7:0] keep;
    automatic int lo;
    if (rst) begin
      m_pend   <= '0;
      m_valid  <= 1'b0;
      m_code   <= 0;
      m_ovf    <= 1'b0;
      model_on <= 1'b1;
    end else begin
      keep = m_pend;
      if (m_valid && ready) keep[m_code] = 1'b0;
      lo = -1;
      for (int i = 0; i < 8; i++) if (keep[i] && lo < 0) lo = i;
      m_ovf  <= ((data_in & keep) != 0);
      m_pend <= keep | data_in;
      if (!m_valid) begin
        if (lo >= 0) begin
          m_valid <= 1'b1;
          m_code  <= lo;
        end
      end else if (ready) begin
        if (lo >= 0) m_code <= lo;
        else m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_valid", int'(valid), int'(m_valid));
      check("model_data_out", int'(data_out), m_code);
      check("model_pending", int'(pending), int'(m_pend));
      check("model_overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    bit [31:0] r;
    rst = 1'b1; data_in = '0; ready = 1'b0;
    tick(); tick();
    check("rst_valid", int'(valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;

    // Walking one
    ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      data_in = 8'(1 << p);
      tick(); data_in = '0;
      check("walk_pend", int'(pending), 1 << p);
      check("walk_idle", int'(valid), 0);
      tick();
      check("walk_valid", int'(valid), 1);
      check("walk_code", int'(data_out), p);
      tick();
      check("walk_drop", int'(valid), 0);
      check("walk_ovf", int'(overflow), 0);
      tick(); tick();
    end

    // Multi-hot burst
    data_in = 8'hA4;
    tick(); data_in = '0;
    check("burst_pend0", int'(pending), 'hA4);
    tick();
    check("burst_code2", int'(data_out), 2);
    check("burst_pend1", int'(pending), 'hA4);
    tick();
    check("burst_code5", int'(data_out), 5);
    check("burst_pend2", int'(pending), 'hA0);
    tick();
    check("burst_code7", int'(data_out), 7);
    check("burst_pend3", int'(pending), 'h80);
    tick();
    check("burst_end", int'(valid), 0);
    check("burst_pend4", int'(pending), 0);

    // Backpressure
    ready = 1'b0; data_in = 8'h40;
    tick(); data_in = '0;
    tick();
    check("bp_code6", int'(data_out), 6);
    data_in = 8'h02;
    tick(); data_in = '0;
    tick(); tick(); tick();
    check("bp_hold6", int'(data_out), 6);
    check("bp_hold_valid", int'(valid), 1);
    ready = 1'b1;
    tick();
    check("bp_code1", int'(data_out), 1);
    check("bp_valid1", int'(valid), 1);
    tick();
    check("bp_end", int'(valid), 0);
    ready = 1'b0;

    // Set beats clear
    data_in = 8'h08;
    tick(); data_in = '0;
    tick();
    check("sbc_code3", int'(data_out), 3);
    ready = 1'b1; data_in = 8'h08;
    tick(); data_in = '0;
    check("sbc_pend", int'(pending), 'h08);
    check("sbc_ovf", int'(overflow), 0);
    tick();
    check("sbc_again_valid", int'(valid), 1);
    check("sbc_again_code", int'(data_out), 3);
    tick();
    check("sbc_end", int'(valid), 0);

    // Overflow
    ready = 1'b0; data_in = 8'h10;
    tick(); data_in = '0;
    tick();
    check("ovf_code4", int'(data_out), 4);
    data_in = 8'h10;
    tick(); data_in = '0;
    check("ovf_pulse", int'(overflow), 1);
    tick();
    check("ovf_clear", int'(overflow), 0);
    ready = 1'b1;
    tick();
    check("ovf_once_valid", int'(valid), 0);
    check("ovf_once_pend", int'(pending), 0);
    tick();
    check("ovf_no_repeat", int'(valid), 0);

    // Reset mid-drain
    ready = 1'b0; data_in = 8'hFF;
    tick(); data_in = '0;
    tick();
    check("rmd_code0", int'(data_out), 0);
    ready = 1'b1;
    tick();
    check("rmd_code1", int'(data_out), 1);
    tick();
    check("rmd_code2", int'(data_out), 2);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("rmd_valid", int'(valid), 0);
    check("rmd_pend", int'(pending), 0);
    check("rmd_dout", int'(data_out), 0);
    check("rmd_ovf", int'(overflow), 0);
    tick(); tick();
    check("rmd_quiet", int'(valid), 0);

    // Randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom;
      data_in = ($urandom_range(0, 3) == 0) ? r[7:0] : 8'h00;
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Drain
    rst = 1'b0; data_in = '0; ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    check("drain_valid", int'(valid), 0);
    check("drain_pend", int'(pending), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
